// File: rtl/ballot_pkg.sv
// ballot_pkg: shared types and constants for the ballot front-end.
//   NUM_BOXES     - number of ballot-box ports merged by ballot_arbiter
//   MODE_*        - request mode encodings
//   candidate_t   - candidate encoding (AIR/FIRE/EARTH/WATER)
//   ballot_req_t  - one buffered request {mode, userID, candidate}
//   out_state_t   - output slot state
//   rr_pick       - round-robin pick helper used by the arbiter
package ballot_pkg;

    localparam int NUM_BOXES = 4;

    localparam logic [1:0] MODE_REGISTER = 2'd0;
    localparam logic [1:0] MODE_VOTE     = 2'd1;

    typedef enum logic [1:0] {
        AIR   = 2'b00,
        FIRE  = 2'b01,
        EARTH = 2'b10,
        WATER = 2'b11
    } candidate_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] userID;
        candidate_t candidate;
    } ballot_req_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_t;

    // Returns {found, index}: the first set bit of req scanning upward from
    // last+1 (mod 4). The loop walks from the farthest candidate to the
    // nearest so the nearest requester overwrites any earlier hit.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ballot_fifo.sv
// ballot_fifo: per-box request FIFO, DEPTH entries (power of two, >= 2).
//   CLK, RST_N  - clock, async active-low reset
//   push, wdata - write request (ignored when full)
//   pop, rdata  - read request (ignored when empty); rdata shows the head
//   full, empty - registered-state status flags
module ballot_fifo
    import ballot_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        push,
    input  ballot_req_t wdata,
    input  logic        pop,
    output ballot_req_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ballot_req_t        mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage, pointers (natural power-of-two wrap) and occupancy count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ballot_arbiter.sv
// ballot_arbiter: buffers requests from four ballot boxes and merges them
// round-robin into one valid/ready stream for the tally stage.
//   CLK, RST_N                           - clock, async active-low reset
//   box_valid/mode/userID/candidate      - per-box request inputs (packed)
//   box_ready                            - per-box FIFO not full
//   out_valid/ready, out_mode/userID/candidate, out_box - merged stream
//   id_err, err_count                    - dropped-request pulse and count
// Optional feature macro: BALLOT_ID_CHECK_EN (drop requests whose
// userID[5:4] does not match the box index). Undefined: id_err and
// err_count are tied to zero.
module ballot_arbiter
    import ballot_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  box_valid,
    input  logic [7:0]  box_mode,
    input  logic [23:0] box_userID,
    input  logic [7:0]  box_candidate,
    output logic [3:0]  box_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_mode,
    output logic [5:0]  out_userID,
    output logic [1:0]  out_candidate,
    output logic [1:0]  out_box,
    output logic        id_err,
    output logic [7:0]  err_count
);

    ballot_req_t wdata_s [NUM_BOXES];
    ballot_req_t rdata_s [NUM_BOXES];
    logic [3:0]  full_s;
    logic [3:0]  empty_s;
    logic [3:0]  accept_s;
    logic [3:0]  push_s;
    logic [3:0]  pop_s;

    out_state_t  state_r;
    out_state_t  state_next_s;
    logic        load_s;
    logic [2:0]  pick_s;
    logic [1:0]  grant_s;
    logic [1:0]  last_grant_r;
    ballot_req_t out_req_r;
    logic [1:0]  out_box_r;

    assign box_ready = ~full_s;
    assign accept_s  = box_valid & box_ready;

    genvar k;
    generate
        for (k = 0; k < NUM_BOXES; k++) begin : g_box
            assign wdata_s[k] = '{mode:      box_mode[2*k +: 2],
                                  userID:    box_userID[6*k +: 6],
                                  candidate: candidate_t'(box_candidate[2*k +: 2])};
            ballot_fifo #(.DEPTH(DEPTH)) u_fifo (
                .CLK   (CLK),
                .RST_N (RST_N),
                .push  (push_s[k]),
                .wdata (wdata_s[k]),
                .pop   (pop_s[k]),
                .rdata (rdata_s[k]),
                .full  (full_s[k]),
                .empty (empty_s[k])
            );
        end
    endgenerate

`ifdef BALLOT_ID_CHECK_EN
    logic [3:0] id_ok_s;
    logic [3:0] mismatch_s;
    logic [2:0] err_inc_s;
    logic [8:0] err_sum_s;
    logic [7:0] err_next_s;
    logic       id_err_r;
    logic [7:0] err_count_r;

    for (k = 0; k < NUM_BOXES; k++) begin : g_id
        assign id_ok_s[k] = (box_userID[6*k+4 +: 2] == 2'(k));
    end

    // Mismatched requests complete the handshake but are never enqueued.
    assign push_s     = accept_s & id_ok_s;
    assign mismatch_s = accept_s & ~id_ok_s;

    // Saturating add of the number of boxes dropped this cycle.
    always_comb begin
        err_inc_s = 3'd0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            err_inc_s = err_inc_s + {2'd0, mismatch_s[i]};
        end
        err_sum_s = {1'b0, err_count_r} + {6'd0, err_inc_s};
        if (err_sum_s > 9'd255) begin
            err_next_s = 8'hFF;
        end else begin
            err_next_s = err_sum_s[7:0];
        end
    end

    // Error pulse and counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            id_err_r    <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            id_err_r    <= |mismatch_s;
            err_count_r <= err_next_s;
        end
    end

    assign id_err    = id_err_r;
    assign err_count = err_count_r;
`else
    assign push_s    = accept_s;
    assign id_err    = 1'b0;
    assign err_count = 8'd0;
`endif

    // Slot FSM: load when the slot is free or being consumed this cycle.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        pop_s        = 4'b0000;
        pick_s       = rr_pick(~empty_s, last_grant_r);
        grant_s      = pick_s[1:0];
        if ((state_r == OUT_EMPTY) || out_ready) begin
            if (pick_s[2]) begin
                load_s         = 1'b1;
                pop_s[grant_s] = 1'b1;
                state_next_s   = OUT_HOLD;
            end else begin
                state_next_s = OUT_EMPTY;
            end
        end else begin
            state_next_s = OUT_HOLD;
        end
    end

    // Slot state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= OUT_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output slot contents and round-robin pointer; held when not loading.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_req_r    <= '0;
            out_box_r    <= 2'd0;
            last_grant_r <= 2'd3;
        end else if (load_s) begin
            out_req_r    <= rdata_s[grant_s];
            out_box_r    <= grant_s;
            last_grant_r <= grant_s;
        end else begin
            out_req_r    <= out_req_r;
            out_box_r    <= out_box_r;
            last_grant_r <= last_grant_r;
        end
    end

    assign out_valid     = (state_r == OUT_HOLD);
    assign out_mode      = out_req_r.mode;
    assign out_userID    = out_req_r.userID;
    assign out_candidate = out_req_r.candidate;
    assign out_box       = out_box_r;

endmodule

// File: doc/ballot_arbiter.md
# ballot_arbiter

- Front-end stage of the avatar-election datapath.
- Collects ballot requests (mode, userID, candidate) from four ballot-box ports, buffers each in a small per-box FIFO, and merges them round-robin into one request stream for the tally stage.
- The output is a valid/ready stream carrying exactly the fields the tally stage consumes.

## Interface
- `DEPTH`, default 2: per-box FIFO depth. Power of two, ≥2.
- `CLK` in 1: clock; all state updates on rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `box_valid` in 4: request present, one bit per box.
- `box_mode` in 8: 2 bits per box; box k uses bits [2k+1:2k]. 0=register, 1=vote.
- `box_userID` in 24: 6 bits per box; box k uses bits [6k+5:6k].
- `box_candidate` in 8: 2 bits per box. 00 Air, 01 Fire, 10 Earth, 11 Water.
- `box_ready` out 4: box k's FIFO can accept.
- `out_valid` out 1: request on `out_*` is valid.
- `out_ready` in 1: tally stage accepts.
- `out_mode` out 2, `out_userID` out 6, `out_candidate` out 2: merged request.
- `out_box` out 2: index of the source box.
- `id_err` out 1: one-cycle pulse when an ID-mismatch request is dropped.
- `err_count` out 8: saturating count of dropped requests.

## Operation
- **Acceptance:** box k is accepted when `box_valid[k]` and `box_ready[k]` are both high at a rising edge.
  - `box_ready[k]` = FIFO k not full.
  - It is a pure function of registered state, with no combinational path from any input.
- **FIFO:** each box has its own FIFO holding {mode, userID, candidate}.
  - Full: count==DEPTH. Empty: count==0.
  - Read and write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
  - A push into a full FIFO cannot occur, because ready is low.
- **Output register:** one slot, state EMPTY or HOLD.
  - EMPTY, or HOLD with `out_ready`=1, allows a load this cycle.
  - On a load: grant the first non-empty FIFO scanning from `last_grant`+1 mod 4, pop it, and load the slot with its entry plus the box index. Set `last_grant` to the granted index. The state becomes or stays HOLD.
  - HOLD with `out_ready`=1 and no non-empty FIFO goes to EMPTY.
  - HOLD with `out_ready`=0 holds all `out_*` stable. There is no pop and `last_grant` does not change.
- **Validity:** `out_valid` = (state==HOLD).
- **Width and arithmetic rules:**
  - `err_count` saturates at 255.
  - FIFO counts are `$clog2(DEPTH)+1` bits.
- The block performs no registration or vote checking. Duplicates pass through unchanged, in order.

## Timing
- **Reset values:**
  - All FIFOs empty, so `box_ready` = 4'hF.
  - `out_valid`=0; `out_mode`, `out_userID`, `out_candidate`, `out_box` all 0.
  - `last_grant`=3, so box 0 has first priority.
  - `id_err`=0, `err_count`=0.
- **Latency:** an entry accepted at edge n can appear on `out_*` at edge n+1 at the earliest (visible in cycle n+1..n+2).
- **Throughput:** sustained one request per cycle with `out_ready` held high.
- **Fairness:** with all four boxes backlogged, grants go 0,1,2,3,0,… with no box starved.
- **Per-box ordering** is strictly FIFO. There is no ordering guarantee across boxes.
- **Reset mid-operation:** asserting `RST_N` low immediately (asynchronously) empties all FIFOs and drops `out_valid`. In-flight requests are lost.

## Configuration
- **`BALLOT_ID_CHECK_EN` defined:**
  - A request at box k whose `userID[5:4]` ≠ k is still accepted (handshake completes) but is not enqueued.
  - `id_err` pulses high for the cycle after acceptance.
  - `err_count` increments; with mismatches on several boxes in the same cycle, it increments once per mismatched box.
- **`BALLOT_ID_CHECK_EN` undefined:**
  - Every accepted request is enqueued.
  - `id_err` and `err_count` are tied to 0; the ports still exist.

## Structure
- **Package `ballot_pkg`:**
  - `NUM_BOXES`=4.
  - Mode constants `MODE_REGISTER`=0, `MODE_VOTE`=1.
  - Candidate typedef/enum: `AIR`, `FIRE`, `EARTH`, `WATER`.
  - Packed struct `ballot_req_t` {mode[1:0], userID[5:0], candidate[1:0]}.
- **Sub-module `ballot_fifo`:** parameterised by `DEPTH`, instantiated four times. Arbiter and output register stay in the top.

## Test plan
- **Reset:** `RST_N`=0 → `box_ready`=4'hF, `out_valid`=0, all `out_*`=0, `err_count`=0.
- **Single request:** box 2 pushes {mode 0, userID 6'h21, cand 01} with `out_ready`=1 → next cycle `out_valid`=1, `out_userID`=6'h21, `out_box`=2; `out_valid`=0 the cycle after.
- **Round-robin:** all boxes valid continuously, userIDs 6'h00/6'h10/6'h20/6'h30, `out_ready`=1 → `out_box` sequence 0,1,2,3,0,1,… with one transfer per cycle.
- **Backpressure:** `out_ready`=0 for 10 cycles with box 1 pushing → `out_*` stable; `box_ready[1]`=0 after DEPTH accepts beyond the slot. On release, entries drain in push order.
- **ID check (macro defined):** box 0 pushes userID 6'h35 → no output, `id_err` pulses once, `err_count`=1. Pushing 300 such requests → `err_count`=255.
- **Reset mid-stream:** `RST_N` low while FIFOs are partly full → `out_valid` drops immediately. After release, no stale entries appear and box 0 is granted first.
